mux_select_sequencer: RTL and testbench

Upstream controller for the `mux8x1` select path. It accepts an 8-bit word over a valid/ready handshake and presents it on the mux data inputs. It then steps the mux select from 0 to 7, holding each select for a programmable dwell time, and samples the mux output. The result is the word re-emitted as an LSB-first serial bit stream. It is the stage that drives `d`/`s` of `mux8x1` and consumes `y`.

---
 rtl/mux_select_sequencer_if.sv | 30 +++
 rtl/mux_select_sequencer.sv | 97 +++++++++
 tb/tb_mux_select_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_select_sequencer_if.sv
// mux_select_sequencer_if
// Bundles the handshake and mux-path signals of mux_select_sequencer.
//   in_valid/in_data/in_ready : upstream word handshake
//   mux_d/mux_s               : registered word and select driven to mux8x1
//   mux_y                     : mux8x1 output fed back for sampling
//   ser_valid/ser_bit/ser_last: LSB-first serial bit stream
//   busy                      : high while a word is being scanned
// slave is the sequencer's view, master is the view of its surroundings.
interface mux_select_sequencer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] mux_d;
  logic [2:0] mux_s;
  logic       mux_y;
  logic       ser_valid;
  logic       ser_bit;
  logic       ser_last;
  logic       busy;

  modport slave (
    input  in_valid, in_data, mux_y,
    output in_ready, mux_d, mux_s, ser_valid, ser_bit, ser_last, busy
  );

  modport master (
    output in_valid, in_data, mux_y,
    input  in_ready, mux_d, mux_s, ser_valid, ser_bit, ser_last, busy
  );
endinterface

// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer
// Accepts an 8-bit word, drives it onto the mux8x1 data inputs and walks the
// select from 0 to 7, holding each select for DWELL cycles before sampling
// mux_y. The sampled bits leave as an LSB-first serial stream.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_select_sequencer_if.slave (handshake, mux path, serial out)
// Parameter:
//   DWELL : cycles each select is held before sampling, legal 1..16
module mux_select_sequencer #(
  parameter int unsigned DWELL = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux_select_sequencer_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // dcnt is 4 bits, so DWELL=16 makes the terminal count 15.
  localparam logic [3:0] DCNT_LAST = 4'(DWELL - 1);

  // An out-of-range dwell would make the counter terminal value wrap.
  if (DWELL == 0 || DWELL > 16) begin : g_dwell_check
    $error("mux_select_sequencer: DWELL=%0d outside legal range 1..16", DWELL);
  end

  state_e     state_q;
  logic [7:0] mux_d_q;
  logic [2:0] mux_s_q;
  logic [3:0] dcnt_q;
  logic       ser_valid_q;
  logic       ser_bit_q;
  logic       ser_last_q;

  // Single FSM block. ser_valid/ser_last default low so they only pulse on
  // the cycle following a sample edge. On the final select the state drops
  // back to IDLE in the same edge that raises ser_last, which lets the next
  // word be accepted at the end of the ser_last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mux_d_q     <= 8'h00;
      mux_s_q     <= 3'b000;
      dcnt_q      <= 4'd0;
      ser_valid_q <= 1'b0;
      ser_bit_q   <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // in_ready is high whenever IDLE and out of reset.
          if (bus.in_valid) begin
            mux_d_q <= bus.in_data;
            mux_s_q <= 3'b000;
            dcnt_q  <= 4'd0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (dcnt_q != DCNT_LAST) begin
            dcnt_q <= dcnt_q + 4'd1;
          end else begin
            dcnt_q      <= 4'd0;
            ser_bit_q   <= bus.mux_y;
            ser_valid_q <= 1'b1;
            if (mux_s_q != 3'd7) begin
              mux_s_q <= mux_s_q + 3'd1;
            end else begin
              // Select stays parked at 7 until the next accept.
              ser_last_q <= 1'b1;
              state_q    <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready looks at rst_n directly so it is low throughout reset and high
  // immediately after release, before any clock edge.
  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.busy      = (state_q == SCAN);
  assign bus.mux_d     = mux_d_q;
  assign bus.mux_s     = mux_s_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_bit   = ser_bit_q;
  assign bus.ser_last  = ser_last_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb_mux_select_sequencer
// Three sequencers (DWELL = 1, 3, 16) share clock and reset, each with a
// behavioural mux8x1 attached. A timeline model derived from the word
// arithmetic (cycles since accept, DWELL) supplies all expected values.
module tb_mux_select_sequencer;

  logic clk;
  logic rst_n;

  mux_select_sequencer_if if0 ();
  mux_select_sequencer_if if1 ();
  mux_select_sequencer_if if2 ();

  mux_select_sequencer #(.DWELL(1))  u_d1  (.clk(clk), .rst_n(rst_n), .bus(if0));
  mux_select_sequencer #(.DWELL(3))  u_d3  (.clk(clk), .rst_n(rst_n), .bus(if1));
  mux_select_sequencer #(.DWELL(16)) u_d16 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Behavioural mux8x1 on each select path.
  assign if0.mux_y = if0.mux_d[if0.mux_s];
  assign if1.mux_y = if1.mux_d[if1.mux_s];
  assign if2.mux_y = if2.mux_d[if2.mux_s];

  logic       vld [3];
  logic [7:0] dat [3];
  logic       rdy [3];
  logic       bsy [3];
  logic [2:0] ms  [3];
  logic [7:0] md  [3];
  logic       sv  [3];
  logic       sb  [3];
  logic       sl  [3];

  assign if0.in_valid = vld[0];
  assign if1.in_valid = vld[1];
  assign if2.in_valid = vld[2];
  assign if0.in_data  = dat[0];
  assign if1.in_data  = dat[1];
  assign if2.in_data  = dat[2];

  assign rdy[0] = if0.in_ready;  assign rdy[1] = if1.in_ready;  assign rdy[2] = if2.in_ready;
  assign bsy[0] = if0.busy;      assign bsy[1] = if1.busy;      assign bsy[2] = if2.busy;
  assign ms[0]  = if0.mux_s;     assign ms[1]  = if1.mux_s;     assign ms[2]  = if2.mux_s;
  assign md[0]  = if0.mux_d;     assign md[1]  = if1.mux_d;     assign md[2]  = if2.mux_d;
  assign sv[0]  = if0.ser_valid; assign sv[1]  = if1.ser_valid; assign sv[2]  = if2.ser_valid;
  assign sb[0]  = if0.ser_bit;   assign sb[1]  = if1.ser_bit;   assign sb[2]  = if2.ser_bit;
  assign sl[0]  = if0.ser_last;  assign sl[1]  = if1.ser_last;  assign sl[2]  = if2.ser_last;

  int vectors = 0;
  int errors  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dwell_of(int idx);
    return (idx == 0) ? 1 : ((idx == 1) ? 3 : 16);
  endfunction

  // Expected {busy, in_ready, mux_s, mux_d, ser_valid, ser_last} c cycles
  // after accepting word w: select k is held over [k*d, (k+1)*d), a bit is
  // presented at every multiple of d from d to 8*d, the last at 8*d.
  function automatic logic [14:0] model(int d, int c, logic [7:0] w);
    logic busy_e;
    logic sv_e;
    logic sl_e;
    int   sel;
    busy_e = (c < 8 * d);
    sv_e   = (c >= d) && (c <= 8 * d) && ((c % d) == 0);
    sl_e   = (c == 8 * d);
    sel    = c / d;
    if (sel > 7) sel = 7;
    return {busy_e, !busy_e, 3'(sel), w, sv_e, sl_e};
  endfunction

  function automatic logic [14:0] observe(int idx);
    return {bsy[idx], rdy[idx], ms[idx], md[idx], sv[idx], sl[idx]};
  endfunction

  task automatic applyStimulus(int idx, logic v, logic [7:0] d);
    vld[idx] = v;
    dat[idx] = d;
  endtask

  // Accepts one word on the chosen sequencer and follows it through to the
  // ser_last cycle. With noise set, in_valid toggles randomly during SCAN.
  task automatic test_word(int idx, logic [7:0] w, bit noise, string name);
    int d;
    logic [14:0] exp_v;
    logic [14:0] obs_v;
    logic [7:0]  wbits;
    d = dwell_of(idx);
    wbits = w;
    vectors++;
    if (rdy[idx] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_ready_pre: got %b expected 1", name, rdy[idx]);
    end
    applyStimulus(idx, 1'b1, w);
    @(posedge clk); #1;
    applyStimulus(idx, 1'b0, 8'($urandom));
    for (int c = 0; c <= 8 * d; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      exp_v = model(d, c, w);
      obs_v = observe(idx);
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL %s_state c=%0d: got %h expected %h", name, c, obs_v, exp_v);
      end
      if (exp_v[1]) begin
        vectors++;
        if (sb[idx] !== wbits[c / d - 1]) begin
          errors++;
          $display("[TB] FAIL %s_bit%0d: got %b expected %b", name, c / d - 1, sb[idx], wbits[c / d - 1]);
        end
      end
      if (noise && c < 8 * d) applyStimulus(idx, 1'($urandom), 8'($urandom));
      else                    applyStimulus(idx, 1'b0, dat[idx]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 8'h00);
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({observe(i), sb[i]} !== 16'h0) begin
        errors++;
        $display("[TB] FAIL reset_values dut%0d: got %h expected 0000", i, {observe(i), sb[i]});
      end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (observe(i) !== {1'b0, 1'b1, 13'h0}) begin
        errors++;
        $display("[TB] FAIL reset_release dut%0d: got %h expected %h", i, observe(i), {1'b0, 1'b1, 13'h0});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp_v;
    logic [14:0] obs_v;
    logic [7:0]  w;
    int c;
    applyStimulus(0, 1'b1, 8'hFF);
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 8'h00);
    for (int t = 0; t <= 17; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      c = (t <= 8) ? t : t - 9;
      w = (t <= 8) ? 8'hFF : 8'h00;
      exp_v = model(1, c, w);
      obs_v = observe(0);
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL b2b_state t=%0d: got %h expected %h", t, obs_v, exp_v);
      end
      if (exp_v[1]) begin
        vectors++;
        if (sb[0] !== w[0]) begin
          errors++;
          $display("[TB] FAIL b2b_bit t=%0d: got %b expected %b", t, sb[0], w[0]);
        end
      end
      if (t == 17) applyStimulus(0, 1'b0, 8'h00);
    end
  endtask

  task automatic test_ignore_valid();
    logic [14:0] exp_v;
    logic [14:0] obs_v;
    logic [7:0]  w;
    int p;
    w = 8'hF0;
    p = $urandom_range(1, 6);
    applyStimulus(0, 1'b1, w);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 8'h00);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      exp_v = model(1, c, w);
      obs_v = observe(0);
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL ignore_state c=%0d: got %h expected %h", c, obs_v, exp_v);
      end
      if (exp_v[1]) begin
        vectors++;
        if (sb[0] !== w[c - 1]) begin
          errors++;
          $display("[TB] FAIL ignore_bit%0d: got %b expected %b", c - 1, sb[0], w[c - 1]);
        end
      end
      if (c == p) applyStimulus(0, 1'b1, 8'h0F);
      else        applyStimulus(0, 1'b0, 8'h00);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [14:0] exp_v;
    logic [7:0]  w;
    w = 8'h5A;
    applyStimulus(0, 1'b1, w);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 8'h00);
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      exp_v = model(1, c, w);
      vectors++;
      if (observe(0) !== exp_v) begin
        errors++;
        $display("[TB] FAIL midrst_pre c=%0d: got %h expected %h", c, observe(0), exp_v);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({observe(i), sb[i]} !== 16'h0) begin
        errors++;
        $display("[TB] FAIL midrst_async dut%0d: got %h expected 0000", i, {observe(i), sb[i]});
      end
    end
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if (observe(0) !== 15'h0) begin
        errors++;
        $display("[TB] FAIL midrst_hold: got %h expected 0000", observe(0));
      end
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (rdy[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_ready: got %b expected 1", rdy[0]);
    end
    test_word(0, 8'h3C, 1'b0, "after_rst_3C");
  endtask

  task automatic test_idle_hold(logic [7:0] w);
    logic [14:0] exp_v;
    exp_v = {1'b0, 1'b1, 3'd7, w, 1'b0, 1'b0};
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (observe(0) !== exp_v) begin
        errors++;
        $display("[TB] FAIL idle_hold k=%0d: got %h expected %h", k, observe(0), exp_v);
      end
    end
  endtask

  task automatic test_random();
    int idx;
    int gap;
    for (int n = 0; n < 10; n++) begin
      idx = (n < 2) ? 2 : $urandom_range(0, 1);
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      test_word(idx, 8'($urandom), 1'b1, "random");
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_word(0, 8'hD3, 1'b0, "d1_D3");
    test_word(1, 8'hA5, 1'b0, "d3_A5");
    test_back_to_back();
    test_ignore_valid();
    test_reset_mid_scan();
    test_idle_hold(8'h3C);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
